pp_pipeline_accel_stride_scale_proc: RTL
========================================

# pp_pipeline_accel_stride_scale_proc

Multi-channel, parametrised successor to the single-channel linestride halving block in the pp_pipeline_accel front end. It captures NCH signed line strides per start, scales each by 2^-shift[c], and returns all results together under ap_ctrl_chain handshake. Each channel has its own shift and a selectable rounding mode (toward zero or floor). Downstream planar/semi-planar address generators use it in place of the fixed divide-by-2 block.

## Interface
- DATA_W, 32, stride/result width in bits; two's complement
- NCH, 3, channel count (1..8)
- SHIFT_W, 3, width of each per-channel shift field; 2^SHIFT_W-1 < DATA_W is required
- ap_clk  in  1  clock, all logic on rising edge
- ap_rst  in  1  synchronous, active-high reset
- ap_start  in  1  start request
- ap_continue  in  1  downstream acknowledge; clears held done
- in_stride  in  NCH*DATA_W  channel c at bits [c*DATA_W +: DATA_W]
- in_shift  in  NCH*SHIFT_W  per-channel shift amount, unsigned
- in_round_floor  in  1  0 = round toward zero, 1 = floor (arithmetic shift)
- ap_done  out  1  high in DONE state or while done is held
- ap_idle  out  1  high when in IDLE and ap_start=0
- ap_ready  out  1  one-cycle pulse in DONE state
- ap_return  out  NCH*DATA_W  registered results, same packing as in_stride

## Operation
- States: IDLE, CALC, DONE; one-hot, reset to IDLE.
- IDLE: a start is accepted when ap_start=1 and done_reg=0. On acceptance, register all of in_stride, in_shift and in_round_floor, clear ch_cnt to 0, and go to CALC. Later input changes are ignored until the next acceptance.
- CALC: process channel ch_cnt in one cycle and write its result into the ap_return slot.
  - Then ch_cnt increments.
  - When ch_cnt = NCH-1, go to DONE.
  - ap_start is ignored in CALC.
- DONE: ap_done=1 and ap_ready=1 for this cycle; go to IDLE.
- done_reg handling:
  - Set done_reg in DONE unless ap_continue=1 in the same cycle.
  - Clear done_reg when ap_continue=1; clear has priority.
  - While done_reg=1, ap_done=1 and no new start is accepted.
- Arithmetic per channel, with x = captured stride and s = captured shift:
  - floor mode: x >>> s (arithmetic shift).
  - toward-zero mode, x<0: -( (-x) >> s ), with the negation taken modulo 2^DATA_W and the shift logical.
  - toward-zero mode, x>=0: x >> s.
  - s=0 returns x unchanged.
  - Negative most-negative input is well defined: with DATA_W=32, x=0x80000000 and s=1 gives 0xC0000000 in both modes.
- ap_return is registered per slot and holds its value until that slot is overwritten in the next run. Slots not yet rewritten in a run keep their previous-run values.
- Reset: ap_return=0, done_reg=0, ch_cnt=0, state IDLE. Reset during CALC or DONE aborts the run with no done and no ready.

## Timing
- Cycle 0: start accepted in IDLE.
- Cycles 1..NCH: CALC, one channel per cycle.
- Cycle NCH+1: DONE, with ap_done and ap_ready pulses.
- Latency from start to done is NCH+1 cycles; with ap_continue held high, the earliest next start is cycle NCH+2.
- ap_return is final and valid from the DONE cycle onward.
- ap_done and ap_idle are combinational from state and done_reg; all other outputs are registered.
- ap_idle is 0 from acceptance through DONE, and also while in IDLE with ap_start=1.
- ap_continue=0 at DONE: ap_done stays high from cycle NCH+2 until the cycle ap_continue=1. A start asserted during this hold waits.
- ap_continue=1 in the same cycle as DONE: done_reg is not set, and ap_done falls the next cycle.

## Test plan
- NCH=3, continue held 1, rounding toward zero, strides {1920,-1920,-3}, shifts {1,1,1}:
  - return {960,-960,-1}.
  - ap_done at cycle 4; ap_ready is a single pulse.
- Same strides, floor mode:
  - return {960,-960,-2}.
  - The same strides with shifts {0,3,7} return {1920,-240,-1}.
- Stride 0x80000000, shift 1:
  - 0xC0000000 in both modes.
  - Stride 0x7FFFFFFF with shift 7 gives 0x00FFFFFF.
- ap_continue held 0 after DONE:
  - ap_done stays 1 for 10 cycles and ap_ready fires only once.
  - With ap_start=1 throughout, no second run starts.
  - Pulsing ap_continue releases the hold; the next start is accepted the following cycle.
- Input changes in mid-run:
  - Changing in_stride during CALC does not affect the result.
  - Back-to-back starts with continue=1 produce runs NCH+2 cycles apart.
- Assert ap_rst during the second CALC cycle:
  - The next cycle shows ap_return=0, ap_done=0 and the state in IDLE.
  - A subsequent start completes normally.

Source files
------------

// File: rtl/pp_pipeline_accel_stride_scale_proc.sv
// Multi-channel signed stride scaler: captures NCH strides per start and divides each by
// 2^shift[c] (toward zero or floor), one channel per cycle, under ap_ctrl_chain handshake.
module pp_pipeline_accel_stride_scale_proc #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NCH     = 3,
  parameter int unsigned SHIFT_W = 3
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst,
  input  logic                    ap_start,
  input  logic                    ap_continue,
  input  logic [NCH*DATA_W-1:0]   in_stride,
  input  logic [NCH*SHIFT_W-1:0]  in_shift,
  input  logic                    in_round_floor,
  output logic                    ap_done,
  output logic                    ap_idle,
  output logic                    ap_ready,
  output logic [NCH*DATA_W-1:0]   ap_return
);

  localparam int unsigned CntW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [2:0] {
    StIdle = 3'b001,
    StCalc = 3'b010,
    StDone = 3'b100
  } state_e;

  state_e              state_q, state_d;
  logic                done_q, done_d;
  logic [CntW-1:0]     cnt_q;
  logic [DATA_W-1:0]   stride_q [NCH];
  logic [SHIFT_W-1:0]  shift_q [NCH];
  logic                floor_q;
  logic [DATA_W-1:0]   ret_q [NCH];

  logic                accept;
  logic                last;
  logic [DATA_W-1:0]   x_cur;
  logic [DATA_W-1:0]   neg_mag;
  logic [SHIFT_W-1:0]  s_cur;
  logic [DATA_W-1:0]   res;

  assign accept = (state_q == StIdle) && ap_start && !done_q;
  assign last   = (cnt_q == CntW'(NCH - 1));
  assign x_cur  = stride_q[cnt_q];
  assign s_cur  = shift_q[cnt_q];

  // Negation wraps modulo 2^DATA_W, so the most-negative input shifts as +2^(DATA_W-1).
  always_comb begin
    neg_mag = -x_cur;
    if (floor_q) begin
      res = $signed(x_cur) >>> s_cur;
    end else if (x_cur[DATA_W-1]) begin
      res = -(neg_mag >> s_cur);
    end else begin
      res = x_cur >> s_cur;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q <= StIdle;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      floor_q <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        stride_q[c] <= '0;
        shift_q[c]  <= '0;
        ret_q[c]    <= '0;
      end
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (accept) begin
        cnt_q   <= '0;
        floor_q <= in_round_floor;
        for (int c = 0; c < NCH; c++) begin
          stride_q[c] <= in_stride[c*DATA_W +: DATA_W];
          shift_q[c]  <= in_shift[c*SHIFT_W +: SHIFT_W];
        end
      end else if (state_q == StCalc) begin
        ret_q[cnt_q] <= res;
        cnt_q        <= cnt_q + CntW'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StCalc;
      StCalc:  if (last) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Continue wins over the set taken in DONE.
  always_comb begin
    done_d = done_q;
    if (ap_continue) begin
      done_d = 1'b0;
    end else if (state_q == StDone) begin
      done_d = 1'b1;
    end
  end

  always_comb begin
    ap_done  = (state_q == StDone) || done_q;
    ap_idle  = (state_q == StIdle) && !ap_start;
    ap_ready = (state_q == StDone);
    for (int c = 0; c < NCH; c++) begin
      ap_return[c*DATA_W +: DATA_W] = ret_q[c];
    end
  end

endmodule
